c16_tap_player: RTL and testbench

- Cassette tape emulator sitting directly upstream of the C16 core.
- Consumes a C16 TAP image streamed byte-wise from the loader and regenerates the datasette read signal that drives the core's cass_in, plus a tape-noise bit for cass_aud.
- Playback advances only while PLAY is pressed and the core's motor control is active; small input FIFO decouples loader from pulse timing.

---
 rtl/c16_tap_player.sv | 200 ++++++++++++++++++++
 tb/tb_c16_tap_player.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/c16_tap_player.sv
// c16_tap_player: buffers a streamed C16 TAP image and replays it as the datasette read signal.
// Define C16_TAP_HALFWAVE_EN to also accept version-2 images (one half-wave per pulse).
module c16_tap_player #(
    parameter int TICK_DIV   = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       CLK28,
    input  logic       RESET_N,
    input  logic       TAP_RESET,
    input  logic [7:0] DIN,
    input  logic       DIN_VALID,
    output logic       DIN_READY,
    input  logic       PLAY,
    input  logic       MOTOR,
    output logic       CASS_IN,
    output logic       CASS_AUD,
    output logic       SENSE,
    output logic       DONE,
    output logic       ERR
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] PMAX    = PW'(TICK_DIV - 1);
    localparam logic [95:0]   MAGIC   = "C16-TAPE-RAW";
`ifdef C16_TAP_HALFWAVE_EN
    localparam logic [7:0] VER_MAX = 8'd2;
`else
    localparam logic [7:0] VER_MAX = 8'd1;
`endif

    typedef enum logic [3:0] {S_HDR, S_FETCH, S_EXT1, S_EXT2, S_EXT3, S_LO, S_HI, S_END, S_ERR} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q;
    logic [PW-1:0] presc_q;
    logic [4:0]    hcnt_q, hcnt_d;
    logic [1:0]    ver_q, ver_d;
    logic [31:0]   size_q, size_d;
    logic [23:0]   dur_q, dur_d, pcnt_q, pcnt_d, d_new, d_eff;
    logic          lvl_q, lvl_d;
    logic          empty, full, wr, rd, run, tick, start, half, payload;
    logic [7:0]    b, magic_b;

    assign empty   = cnt_q == '0;
    assign full    = cnt_q == DEPTH_C;
    assign wr      = DIN_VALID & ~full & ~TAP_RESET;
    assign b       = mem_q[rp_q];
    assign run     = PLAY & MOTOR;
    assign tick    = run && presc_q == PMAX;
    assign magic_b = 8'(MAGIC >> {4'd11 - hcnt_q[3:0], 3'b000});
    assign d_eff   = (d_new == '0) ? 24'd1 : d_new;
`ifdef C16_TAP_HALFWAVE_EN
    assign half = ver_q == 2'd2;
`else
    assign half = 1'b0;
`endif

    always_ff @(posedge CLK28)
        if (wr) mem_q[wp_q] <= DIN;

    // TAP_RESET wins over a concurrent write: wr is already masked, pointers clear here
    always_ff @(posedge CLK28 or negedge RESET_N)
        if (!RESET_N) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else if (TAP_RESET) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_q + AW'(wr);
            rp_q  <= rp_q + AW'(rd);
            cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
        end

    always_ff @(posedge CLK28 or negedge RESET_N)
        if (!RESET_N) begin
            state_q <= S_HDR;
            hcnt_q  <= '0;
            ver_q   <= '0;
            size_q  <= '0;
            dur_q   <= '0;
            pcnt_q  <= '0;
            lvl_q   <= 1'b1;
            presc_q <= '0;
        end else if (TAP_RESET) begin
            state_q <= S_HDR;
            hcnt_q  <= '0;
            ver_q   <= '0;
            size_q  <= '0;
            dur_q   <= '0;
            pcnt_q  <= '0;
            lvl_q   <= 1'b1;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            ver_q   <= ver_d;
            size_q  <= size_d;
            dur_q   <= dur_d;
            pcnt_q  <= pcnt_d;
            lvl_q   <= lvl_d;
            presc_q <= tick ? '0 : presc_q + PW'(run);
        end

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        ver_d   = ver_q;
        size_d  = size_q;
        dur_d   = dur_q;
        pcnt_d  = pcnt_q;
        lvl_d   = lvl_q;
        rd      = 1'b0;
        start   = 1'b0;
        d_new   = '0;
        case (state_q)
            S_HDR: if (!empty) begin
                rd     = 1'b1;
                hcnt_d = hcnt_q + 5'd1;
                if (hcnt_q < 5'd12) state_d = (b == magic_b) ? S_HDR : S_ERR;
                else if (hcnt_q == 5'd12) begin
                    ver_d   = b[1:0];
                    state_d = (b <= VER_MAX) ? S_HDR : S_ERR;
                end else if (hcnt_q >= 5'd16) begin
                    size_d = {b, size_q[31:8]};
                    if (hcnt_q == 5'd19) state_d = (size_d == '0) ? S_END : S_FETCH;
                end
            end
            S_FETCH: if (run && !empty) begin
                rd     = 1'b1;
                size_d = size_q - 32'd1;
                if (b != 8'd0) begin
                    start = 1'b1;
                    d_new = {13'd0, b, 3'd0};
                end else if (ver_q == 2'd0) begin
                    start = 1'b1;
                    d_new = 24'd2048;
                end else if (size_q == 32'd1) start = 1'b1;
                else state_d = S_EXT1;
            end
            S_EXT1: if (run && !empty) begin
                rd      = 1'b1;
                size_d  = size_q - 32'd1;
                dur_d   = {16'd0, b};
                d_new   = dur_d;
                start   = size_q == 32'd1;
                state_d = S_EXT2;
            end
            S_EXT2: if (run && !empty) begin
                rd      = 1'b1;
                size_d  = size_q - 32'd1;
                dur_d   = {8'd0, b, dur_q[7:0]};
                d_new   = dur_d;
                start   = size_q == 32'd1;
                state_d = S_EXT3;
            end
            S_EXT3: if (run && !empty) begin
                rd     = 1'b1;
                size_d = size_q - 32'd1;
                d_new  = {b, dur_q[15:0]};
                start  = 1'b1;
            end
            S_LO: if (tick) begin
                pcnt_d = pcnt_q - 24'd1;
                if (pcnt_q == 24'd1) begin
                    state_d = S_HI;
                    pcnt_d  = dur_q - {1'b0, dur_q[23:1]};
                end
            end
            S_HI: if (tick) begin
                pcnt_d = pcnt_q - 24'd1;
                if (pcnt_q == 24'd1) state_d = (size_q == '0) ? S_END : S_FETCH;
            end
            S_END, S_ERR: rd = ~empty;
            default: state_d = S_HDR;
        endcase
        // a pulse with no low half (D=1) or a half-wave pulse goes straight to the high phase
        if (start) begin
            dur_d   = d_eff;
            pcnt_d  = (half || d_eff[23:1] == '0) ? d_eff : {1'b0, d_eff[23:1]};
            state_d = (half || d_eff[23:1] == '0) ? S_HI : S_LO;
            lvl_d   = half ? ~lvl_q : lvl_q;
        end
    end

    always_comb begin
        payload   = state_q inside {S_FETCH, S_EXT1, S_EXT2, S_EXT3, S_LO, S_HI};
        CASS_IN   = (state_q == S_LO) ? 1'b0 : (half && payload) ? lvl_q : 1'b1;
        CASS_AUD  = run & payload & CASS_IN;
        DONE      = state_q == S_END;
        ERR       = state_q == S_ERR;
        SENSE     = PLAY & ~DONE;
        DIN_READY = ~full;
    end
endmodule

// File: tb/tb_c16_tap_player.sv
// tb_c16_tap_player: directed self-checking bench for c16_tap_player at TICK_DIV=32, FIFO_DEPTH=8.
module tb_c16_tap_player;
    logic       clk = 1'b0, rst_n = 1'b0, tap_reset = 1'b0, din_valid = 1'b0, play = 1'b0, motor = 1'b0;
    logic [7:0] din = 8'd0;
    logic       din_ready, cass_in, cass_aud, sense, done, err;
    int         errors = 0, checks = 0;

    always #5 clk = ~clk;

    c16_tap_player dut (
        .CLK28(clk), .RESET_N(rst_n), .TAP_RESET(tap_reset), .DIN(din), .DIN_VALID(din_valid),
        .DIN_READY(din_ready), .PLAY(play), .MOTOR(motor), .CASS_IN(cass_in), .CASS_AUD(cass_aud),
        .SENSE(sense), .DONE(done), .ERR(err)
    );

    task automatic push(input logic [7:0] v);
        int w = 0;
        din = v;
        din_valid = 1'b1;
        while (!din_ready && w < 5000) begin @(negedge clk); w++; end
        if (!din_ready) begin
            checks++; errors++;
            $display("FAIL push_timeout: din_ready=%b after %0d cycles, want 1", din_ready, w);
        end
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] ver, input logic [31:0] size);
        logic [95:0] m = "C16-TAPE-RAW";
        for (int i = 0; i < 12; i++) push(m[95-8*i -: 8]);
        push(ver);
        for (int i = 0; i < 3; i++) push(8'h00);
        for (int i = 0; i < 4; i++) push(size[8*i +: 8]);
    endtask

    task automatic tap_pulse();
        tap_reset = 1'b1;
        @(negedge clk);
        tap_reset = 1'b0;
    endtask

    task automatic test_reset();
        play = 1'b1; motor = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (cass_in !== 1'b1) begin errors++; $display("FAIL reset_held_cass_in: got %b want 1", cass_in); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_din_ready: got %b want 1", din_ready); end
        checks++; if (cass_in !== 1'b1) begin errors++; $display("FAIL reset_cass_in: got %b want 1", cass_in); end
        checks++; if (cass_aud !== 1'b0) begin errors++; $display("FAIL reset_cass_aud: got %b want 0", cass_aud); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (sense !== 1'b1) begin errors++; $display("FAIL reset_sense: got %b want 1", sense); end
        play = 1'b0;
    endtask

    // v1, one byte 0x10: D=128 ticks, 64 low then 64 high
    task automatic test_basic();
        int w = 0, n = 0, m = 0;
        tap_pulse();
        play = 1'b0; motor = 1'b1;
        send_hdr(8'd1, 32'd1);
        push(8'h10);
        repeat (5) @(negedge clk);
        checks++; if (cass_in !== 1'b1) begin errors++; $display("FAIL basic_stall_cass_in: got %b want 1", cass_in); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_stall_done: got %b want 0", done); end
        play = 1'b1;
        do begin @(negedge clk); w++; end while (cass_in && w < 100);
        checks++; if (w != 1) begin errors++; $display("FAIL basic_lo_start: got %0d cycles want 1", w); end
        while (!cass_in && n < 5000) begin n++; @(negedge clk); end
        // the first tick of the phase may be partial, so low spans 63..64 full tick periods
        checks++; if (n < 2016 || n > 2048) begin errors++; $display("FAIL basic_lo_len: got %0d cycles want 2016..2048", n); end
        checks++; if (cass_aud !== 1'b1) begin errors++; $display("FAIL basic_aud_hi: got %b want 1", cass_aud); end
        while (!done && m < 5000) begin m++; @(negedge clk); end
        checks++; if (m != 2048) begin errors++; $display("FAIL basic_hi_len: got %0d cycles want 2048", m); end
        checks++; if (cass_in !== 1'b1) begin errors++; $display("FAIL basic_end_cass_in: got %b want 1", cass_in); end
        checks++; if (sense !== 1'b0) begin errors++; $display("FAIL basic_end_sense: got %b want 0", sense); end
        checks++; if (cass_aud !== 1'b0) begin errors++; $display("FAIL basic_end_aud: got %b want 0", cass_aud); end
    endtask

    // v1 extended pulse 00 03 01 00: D=0x000103=259, low 129 ticks, high 130 ticks
    task automatic test_ext();
        int w = 0, n = 0, m = 0;
        tap_pulse();
        play = 1'b0; motor = 1'b1;
        send_hdr(8'd1, 32'd4);
        push(8'h00); push(8'h03); push(8'h01); push(8'h00);
        repeat (5) @(negedge clk);
        play = 1'b1;
        do begin @(negedge clk); w++; end while (cass_in && w < 100);
        checks++; if (w > 8) begin errors++; $display("FAIL ext_lo_start: got %0d cycles want <=8", w); end
        while (!cass_in && n < 10000) begin n++; @(negedge clk); end
        checks++; if (n < 4096 || n > 4128) begin errors++; $display("FAIL ext_lo_len: got %0d cycles want 4096..4128", n); end
        while (!done && m < 10000) begin m++; @(negedge clk); end
        checks++; if (m != 4160) begin errors++; $display("FAIL ext_hi_len: got %0d cycles want 4160", m); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ext_done: got %b want 1", done); end
    endtask

    task automatic test_error();
        logic bad = 1'b0;
        tap_pulse();
        play = 1'b0;
        push(8'h58);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_early: got %b want 0", err); end
        @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_flag: got %b want 1", err); end
        din = 8'h00; din_valid = 1'b1;
        repeat (25) begin if (!din_ready) bad = 1'b1; @(negedge clk); end
        din_valid = 1'b0;
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL err_drain_ready: stall seen=%b want 0", bad); end
        checks++; if (cass_in !== 1'b1) begin errors++; $display("FAIL err_cass_in: got %b want 1", cass_in); end
        checks++; if (err !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL err_hold: err=%b done=%b want 1 0", err, done); end
    endtask

    task automatic test_backpressure();
        int acc = 0, m = 0;
        tap_pulse();
        play = 1'b1; motor = 1'b0;
        send_hdr(8'd1, 32'd8);
        repeat (3) @(negedge clk);
        din = 8'h01; din_valid = 1'b1;
        repeat (30) begin if (din_ready) acc++; @(negedge clk); end
        din_valid = 1'b0;
        checks++; if (acc != 8) begin errors++; $display("FAIL bp_accepted: got %0d want 8", acc); end
        checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b want 0", din_ready); end
        motor = 1'b1;
        @(negedge clk);
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL bp_resume_ready: got %b want 1", din_ready); end
        while (!done && m < 4000) begin m++; @(negedge clk); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b want 1 after %0d cycles", done, m); end
    endtask

    // byte 0x02: D=16, 8 low ticks; uninterrupted low would span 31+7*32=255 cycles from presc=1
    task automatic test_pause();
        int w = 0, n = 0, m = 0;
        logic bad = 1'b0;
        tap_pulse();
        play = 1'b0; motor = 1'b1;
        send_hdr(8'd1, 32'd1);
        push(8'h02);
        repeat (5) @(negedge clk);
        play = 1'b1;
        do begin @(negedge clk); w++; end while (cass_in && w < 100);
        repeat (169) @(negedge clk);
        checks++; if (cass_in !== 1'b0) begin errors++; $display("FAIL pause_pre_lo: got %b want 0", cass_in); end
        motor = 1'b0;
        repeat (1000) begin @(negedge clk); if (cass_in !== 1'b0 || cass_aud !== 1'b0) bad = 1'b1; end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL pause_frozen: change seen=%b want 0", bad); end
        motor = 1'b1;
        do begin @(negedge clk); n++; end while (!cass_in && n < 500);
        // 170 low cycles already seen, 255-170=85 remain, high appears on the 86th
        checks++; if (n != 86) begin errors++; $display("FAIL pause_resume_lo: got %0d cycles want 86", n); end
        while (!done && m < 500) begin m++; @(negedge clk); end
        checks++; if (m != 256) begin errors++; $display("FAIL pause_hi_len: got %0d cycles want 256", m); end
    endtask

    task automatic test_tap_reset();
        int w = 0, m = 0;
        tap_pulse();
        play = 1'b0; motor = 1'b1;
        send_hdr(8'd1, 32'd2);
        push(8'h10); push(8'h20);
        repeat (5) @(negedge clk);
        play = 1'b1;
        do begin @(negedge clk); w++; end while (cass_in && w < 100);
        repeat (100) @(negedge clk);
        din = 8'h43; din_valid = 1'b1; tap_reset = 1'b1;
        @(negedge clk);
        tap_reset = 1'b0; din_valid = 1'b0;
        checks++; if (cass_in !== 1'b1) begin errors++; $display("FAIL tr_cass_in: got %b want 1", cass_in); end
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL tr_ready: got %b want 1", din_ready); end
        checks++; if (err !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL tr_flags: err=%b done=%b want 0 0", err, done); end
        send_hdr(8'd0, 32'd1);
        push(8'h01);
        while (!done && m < 1000) begin m++; @(negedge clk); end
        checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL tr_replay: done=%b err=%b want 1 0", done, err); end
    endtask

    task automatic test_size0();
        tap_pulse();
        play = 1'b1; motor = 1'b0;
        send_hdr(8'd1, 32'd0);
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL size0_done: got %b want 1", done); end
        checks++; if (sense !== 1'b0) begin errors++; $display("FAIL size0_sense: got %b want 0", sense); end
        checks++; if (err !== 1'b0 || cass_in !== 1'b1) begin errors++; $display("FAIL size0_lvl: err=%b cass_in=%b want 0 1", err, cass_in); end
        push(8'h11); push(8'h22); push(8'h33);
        @(negedge clk);
        checks++; if (din_ready !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL size0_drain: ready=%b done=%b want 1 1", din_ready, done); end
    endtask

    task automatic test_version();
        logic exp2;
`ifdef C16_TAP_HALFWAVE_EN
        exp2 = 1'b0;
`else
        exp2 = 1'b1;
`endif
        tap_pulse();
        play = 1'b0;
        send_hdr(8'd2, 32'd4);
        @(negedge clk);
        checks++; if (err !== exp2) begin errors++; $display("FAIL ver2_err: got %b want %b", err, exp2); end
        tap_pulse();
        send_hdr(8'd3, 32'd4);
        @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ver3_err: got %b want 1", err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ext();
        test_error();
        test_backpressure();
        test_pause();
        test_tap_reset();
        test_size0();
        test_version();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
